// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmitter.
// Optional 9-bit frame support is enabled by defining SERIAL_TX_NINE_BIT_EN.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_NINTH = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_e;

    localparam logic [1:0] SM_UART8 = 2'b01;
    localparam logic [1:0] SM_UART9 = 2'b11;

    localparam int DIV_FAST  = 16;
    localparam int DIV_SLOW  = 32;
    localparam int TICK_W    = $clog2(DIV_SLOW);
    localparam int DATA_BITS = 8;
    localparam int BIT_CNT_W = $clog2(DATA_BITS);

    // Terminal tick count of one bit period for the given baud-doubler setting.
    function automatic logic [TICK_W-1:0] div_last(input logic smod);
        return smod ? TICK_W'(DIV_FAST - 1) : TICK_W'(DIV_SLOW - 1);
    endfunction

    function automatic logic mode_valid(input logic [1:0] sm);
        return (sm == SM_UART8) || (sm == SM_UART9);
    endfunction

endpackage

// File: rtl/serial_baud_div.sv
// Bit-period divider: counts baud ticks and pulses bit_end on the last tick of
// each bit (16 or 32 ticks, selected by the frame-latched smod).
module serial_baud_div
    import serial_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic baud_tick,
    input  logic restart,
    input  logic smod,
    output logic bit_end
);

    logic [TICK_W-1:0] cnt_q;
    logic [TICK_W-1:0] cnt_d;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        cnt_d   = cnt_q;
        bit_end = 1'b0;
        if (restart) begin
            cnt_d = '0;
        end else if (baud_tick) begin
            if (cnt_q == div_last(smod)) begin
                cnt_d   = '0;
                bit_end = 1'b1;
            end else begin
                cnt_d = cnt_q + TICK_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // together from values sampled at the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// UART-style serial transmitter: start bit, 8 data bits LSB first, optional
// ninth bit (tb8, only when SERIAL_TX_NINE_BIT_EN is defined), stop bit.
module serial_tx
    import serial_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic [1:0] sm,
    input  logic       smod,
    input  logic       sbuf_wr,
    input  logic [7:0] sbuf_data,
    input  logic       tb8,
    input  logic       ti_clr,
    output logic       txd,
    output logic       ti,
    output logic       busy
);

    tx_state_e              state_q;
    tx_state_e              state_d;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_d;
    logic                   smod_q;
    logic                   ti_q;
    logic                   ti_d;
    logic                   accept;
    logic                   bit_end;

`ifdef SERIAL_TX_NINE_BIT_EN
    logic                   nine_q;
    logic                   tb8_q;
`else
    logic                   unused_tb8;
    assign unused_tb8 = tb8;
`endif

    assign accept = sbuf_wr && (state_q == ST_IDLE) && mode_valid(sm);

    serial_baud_div u_baud_div (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .restart   (accept),
        .smod      (smod_q),
        .bit_end   (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_START;
                    shift_d   = sbuf_data;
                    bit_cnt_d = '0;
                end
            end
            ST_START: begin
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
`ifdef SERIAL_TX_NINE_BIT_EN
                        state_d = nine_q ? ST_NINTH : ST_STOP;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_NINE_BIT_EN
            ST_NINTH: begin
                if (bit_end) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A fresh set on STOP entry takes priority over a simultaneous clear.
    always_comb begin
        ti_d = ti_q && !ti_clr;
        if ((state_d == ST_STOP) && (state_q != ST_STOP)) ti_d = 1'b1;
    end

    always_comb begin
        txd = 1'b1;
        unique case (state_q)
            ST_START: txd = 1'b0;
            ST_DATA:  txd = shift_q[0];
`ifdef SERIAL_TX_NINE_BIT_EN
            ST_NINTH: txd = tb8_q;
`endif
            default:  txd = 1'b1;
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign ti   = ti_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            ti_q      <= ti_d;
        end
    end

    // Frame parameters are captured once per accepted write and held to frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smod_q <= 1'b0;
        end else if (accept) begin
            smod_q <= smod;
        end
    end

`ifdef SERIAL_TX_NINE_BIT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nine_q <= 1'b0;
            tb8_q  <= 1'b0;
        end else if (accept) begin
            nine_q <= (sm == SM_UART9);
            tb8_q  <= tb8;
        end
    end
`endif

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: directed frames plus randomized traffic
// compared every cycle against a tick-counting frame model.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic [1:0] sm = 2'b01;
    logic       smod = 1'b1;
    logic       sbuf_wr = 1'b0;
    logic [7:0] sbuf_data = 8'h00;
    logic       tb8 = 1'b0;
    logic       ti_clr = 1'b0;
    logic       txd;
    logic       ti;
    logic       busy;

    serial_tx dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .sm        (sm),
        .smod      (smod),
        .sbuf_wr   (sbuf_wr),
        .sbuf_data (sbuf_data),
        .tb8       (tb8),
        .ti_clr    (ti_clr),
        .txd       (txd),
        .ti        (ti),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int tick_period = 1;   // 0 selects random ticks

    // Frame model: a frame is a list of line levels, each held for div ticks.
    bit m_active  = 1'b0;
    int m_elapsed = 0;
    int m_div     = 16;
    int m_nbits   = 10;
    int m_bits[11];
    bit m_ti      = 1'b0;

    logic hist_txd[$];
    logic hist_busy[$];
    logic hist_ti[$];
    int   ti_rises = 0;
    logic prev_ti  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic bit nine_mode(input logic [1:0] s);
`ifdef SERIAL_TX_NINE_BIT_EN
        return s == 2'b11;
`else
        return (s == 2'b11) && 1'b0;
`endif
    endfunction

    function automatic logic m_txd();
        if (!m_active) return 1'b1;
        return m_bits[m_elapsed / m_div] != 0;
    endfunction

    task automatic model_update();
        bit set_ti;
        set_ti = 1'b0;
        if (rst) begin
            m_active  = 1'b0;
            m_elapsed = 0;
            m_ti      = 1'b0;
            return;
        end
        if (m_active) begin
            if (baud_tick) begin
                m_elapsed++;
                if (m_elapsed == (m_nbits - 1) * m_div) set_ti = 1'b1;
                if (m_elapsed == m_nbits * m_div) m_active = 1'b0;
            end
        end else if (sbuf_wr && (sm == 2'b01 || sm == 2'b11)) begin
            m_active  = 1'b1;
            m_elapsed = 0;
            m_div     = smod ? 16 : 32;
            m_nbits   = nine_mode(sm) ? 11 : 10;
            m_bits[0] = 0;
            for (int i = 0; i < 8; i++) m_bits[i+1] = int'(sbuf_data[i]);
            if (m_nbits == 11) m_bits[9] = int'(tb8);
            m_bits[m_nbits-1] = 1;
        end
        if (set_ti) m_ti = 1'b1;
        else if (ti_clr) m_ti = 1'b0;
    endtask

    task automatic step();
        baud_tick = (tick_period == 0) ? 1'($urandom_range(0, 1)) : ((cyc % tick_period) == 0);
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        check("line{txd,busy,ti}", {29'd0, txd, busy, ti}, {29'd0, m_txd(), m_active, m_ti});
        hist_txd.push_back(txd);
        hist_busy.push_back(busy);
        hist_ti.push_back(ti);
        if (ti && !prev_ti) ti_rises++;
        prev_ti = ti;
        sbuf_wr = 1'b0;
        ti_clr  = 1'b0;
    endtask

    task automatic align();
        if (tick_period > 0) while ((cyc % tick_period) != 0) step();
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] s, input logic sd, input logic t8);
        sbuf_data = d;
        sm        = s;
        smod      = sd;
        tb8       = t8;
        sbuf_wr   = 1'b1;
        hist_txd.delete();
        hist_busy.delete();
        hist_ti.delete();
        ti_rises = 0;
        prev_ti  = ti;
        step();
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (m_active && n < budget) begin
            step();
            n++;
        end
        check("frame_within_budget", n < budget, 1'b1);
        repeat (3) step();
        check("idle_after_frame", busy, 1'b0);
    endtask

    function automatic int busy_cycles();
        int c;
        c = 0;
        foreach (hist_busy[i]) if (hist_busy[i]) c++;
        return c;
    endfunction

    function automatic int first_ti();
        foreach (hist_ti[i]) if (hist_ti[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] decode(input int len);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = hist_txd[(i + 1) * len + len / 2];
        return b;
    endfunction

    task automatic clear_ti();
        ti_clr = 1'b1;
        step();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic exp_a5[10];
        int   wait_n;
        int   nb9;
        exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset state, observed before any clock edge.
        #1;
        check("reset_txd", txd, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_ti", ti, 1'b0);
        repeat (2) step();
        rst = 1'b0;
        step();

        // 8'hA5, 8-bit mode, 16 ticks/bit, tick every 4 cycles: 64-cycle bits.
        tick_period = 4;
        align();
        send(8'hA5, 2'b01, 1'b1, 1'b0);
        run_until_idle(2000);
        for (int k = 0; k < 10; k++) check($sformatf("a5_bit%0d", k), hist_txd[k*64+32], exp_a5[k]);
        check("a5_start_last", hist_txd[63], 1'b0);
        check("a5_bit0_first", hist_txd[64], 1'b1);
        check("a5_busy_cycles", busy_cycles(), 640);
        check("a5_ti_rise", first_ti(), 576);

        // sm=11, 32 ticks/bit, data 8'h00, tb8=1.
        clear_ti();
        tick_period = 1;
        send(8'h00, 2'b11, 1'b0, 1'b1);
        run_until_idle(1000);
`ifdef SERIAL_TX_NINE_BIT_EN
        nb9 = 11;
`else
        nb9 = 10;
`endif
        check("n9_busy_cycles", busy_cycles(), nb9 * 32);
        check("n9_start", hist_txd[16], 1'b0);
        check("n9_data7", hist_txd[8*32+16], 1'b0);
        check("n9_bit9", hist_txd[9*32+16], 1'b1);

        // ti_clr coinciding with the set, then one cycle later.
        clear_ti();
        tick_period = 1;
        send(8'h81, 2'b01, 1'b1, 1'b0);
        wait_n = 0;
        while (!(m_active && m_elapsed == (m_nbits - 1) * m_div - 1) && wait_n < 400) begin
            step();
            wait_n++;
        end
        ti_clr = 1'b1;
        step();
        check("ti_set_wins", ti, 1'b1);
        ti_clr = 1'b1;
        step();
        check("ti_clr_next", ti, 1'b0);
        check("ti_clr_frame_busy", busy, 1'b1);
        run_until_idle(400);

        // Write of 8'hFF while 8'h3C is on the line.
        clear_ti();
        tick_period = 2;
        align();
        send(8'h3C, 2'b01, 1'b1, 1'b0);
        repeat (100) step();
        sbuf_data = 8'hFF;
        sbuf_wr   = 1'b1;
        step();
        run_until_idle(1000);
        check("dbl_data", decode(32), 8'h3C);
        check("dbl_ti_once", ti_rises, 1);
        check("dbl_busy_cycles", busy_cycles(), 320);

        // Asynchronous reset during data bit 3 (ti still set from last frame).
        tick_period = 1;
        send(8'hC3, 2'b01, 1'b1, 1'b0);
        wait_n = 0;
        while (m_elapsed != 4 * 16 + 8 && wait_n < 400) begin
            step();
            wait_n++;
        end
        check("pre_rst_ti", ti, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_txd", txd, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_ti", ti, 1'b0);
        m_active  = 1'b0;
        m_elapsed = 0;
        m_ti      = 1'b0;
        prev_ti   = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();
        send(8'h55, 2'b01, 1'b1, 1'b0);
        run_until_idle(400);
        check("post_rst_data", decode(16), 8'h55);
        check("post_rst_ti_once", ti_rises, 1);

        // Unsupported mode is ignored; mode/baud changes mid-frame do nothing.
        sbuf_data = 8'h5A;
        sm        = 2'b10;
        sbuf_wr   = 1'b1;
        step();
        repeat (20) step();
        check("sm10_busy", busy, 1'b0);
        check("sm10_txd", txd, 1'b1);
        tick_period = 2;
        align();
        send(8'h96, 2'b01, 1'b1, 1'b0);
        repeat (50) step();
        smod = 1'b0;
        sm   = 2'b11;
        repeat (150) step();
        smod = 1'b1;
        run_until_idle(1000);
        check("smod_busy_cycles", busy_cycles(), 320);
        check("smod_data", decode(32), 8'h96);

        // Randomized traffic: writes, modes, ti clears, rare resets, random ticks.
        tick_period = 0;
        for (int c = 0; c < 6000; c++) begin
            int r;
            r = int'($urandom_range(0, 7));
            sm        = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : (r < 5) ? 2'b01 : 2'b11;
            smod      = 1'($urandom_range(0, 1));
            sbuf_data = 8'($urandom);
            tb8       = 1'($urandom_range(0, 1));
            sbuf_wr   = ($urandom_range(0, 9) == 0);
            ti_clr    = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 1999) == 0);
            step();
        end
        rst = 1'b0;
        run_until_idle(3000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with the ports listed below.
REQ-002 clk  input  1  system clock; all state advances on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 baud_tick  input  1  one-cycle pulse from timer overflow (t_o of the baud timer).
REQ-005 sm  input  2  serial mode: 2'b01 = 8-bit UART, 2'b11 = 9-bit UART; 2'b00 and 2'b10 are unsupported.
REQ-006 smod  input  1  baud doubler: 1 = 16 ticks per bit, 0 = 32 ticks per bit.
REQ-007 sbuf_wr  input  1  one-cycle write strobe for the transmit buffer.
REQ-008 sbuf_data  input  8  byte to transmit.
REQ-009 tb8  input  1  ninth data bit for 9-bit frames.
REQ-010 ti_clr  input  1  software clear of ti.
REQ-011 txd  output  1  serial line; idle level is 1.
REQ-012 ti  output  1  transmit-interrupt flag, sticky.
REQ-013 busy  output  1  high while a frame is in progress.

Function
REQ-014 When sbuf_wr is high, the block is idle and sm is 01 or 11, it SHALL accept the write and latch sbuf_data, tb8, sm and smod for the whole frame.
REQ-015 A write SHALL be ignored with no state change if it arrives while busy is high or while sm is 00 or 10.
REQ-016 FSM states: IDLE, START, DATA, NINTH, STOP.
REQ-017 FSM transitions: IDLE->START on an accepted write; START->DATA; DATA->NINTH (9-bit frame) or DATA->STOP (8-bit frame) after 8 bits; NINTH->STOP; STOP->IDLE.
REQ-018 Latency: on an accepted write in cycle N, txd SHALL be 0 (start bit) and busy SHALL be 1 from cycle N+1.
REQ-019 Bit period: each bit SHALL last exactly DIV baud_tick pulses, where DIV = 16 if the latched smod is 1 and 32 otherwise.
REQ-020 The tick counter SHALL reset to 0 on an accepted write.
REQ-021 A state advance SHALL occur in the cycle of the DIV-th tick of a bit.
REQ-022 Data bits SHALL be sent LSB first; the ninth bit is the latched tb8; the stop bit is 1.
REQ-023 ti SHALL be set in the cycle the FSM enters STOP.
REQ-024 If the set of ti and ti_clr occur in the same cycle, the set SHALL win.
REQ-025 ti_clr SHALL have no effect on an active frame.
REQ-026 busy SHALL fall, and txd SHALL stay 1, in the cycle STOP->IDLE occurs.
REQ-027 A write in the same cycle as STOP->IDLE SHALL be ignored; the earliest accepted write is the next cycle.
REQ-028 Changes to sm or smod mid-frame SHALL have no effect on the current frame.
REQ-029 When baud_tick is absent, the FSM SHALL hold its state and txd SHALL hold its value indefinitely.

Reset
REQ-030 While rst is high, txd SHALL be 1, ti SHALL be 0, busy SHALL be 0, the FSM SHALL be IDLE, and the tick and bit counters and the shift register SHALL be 0, all taking effect immediately.
REQ-031 A reset asserted mid-frame SHALL abort the frame with no partial stop bit and no ti.

Configuration
REQ-032 With SERIAL_TX_NINE_BIT_EN defined, sm=11 SHALL produce 11-bit frames (start, 8 data bits, tb8, stop).
REQ-033 Without SERIAL_TX_NINE_BIT_EN, the NINTH state and tb8 latch SHALL be absent, and sm=11 SHALL behave exactly as sm=01 (10-bit frame).

Structure
REQ-034 The shared package serial_pkg SHALL hold: the FSM state encoding, the mode constants SM_UART8=2'b01 and SM_UART9=2'b11, and the DIV constants DIV_FAST=16 and DIV_SLOW=32.
REQ-035 The sub-module serial_baud_div SHALL implement the tick counter: inputs baud_tick, restart and the latched smod; output bit_end, a one-cycle pulse on the DIV-th tick.

Verification
REQ-036 The bench SHALL cover: sm=01, smod=1, write 8'hA5, baud_tick every 4 cycles -> txd sequence 0,1,0,1,0,0,1,0,1,1, each bit 64 cycles; ti rises at the stop-bit start; busy is low after 640 cycles.
REQ-037 The bench SHALL cover: with the macro defined, sm=11, smod=0, data 8'h00, tb8=1 -> 11 bits, each 32 ticks; the ninth bit is 1.
REQ-038 The bench SHALL cover: a second write of 8'hFF during a frame of 8'h3C -> it is ignored; the line shows only 8'h3C and ti sets once.
REQ-039 The bench SHALL cover: ti_clr pulsed in the cycle ti sets -> ti ends the cycle at 1; ti_clr one cycle later -> ti goes to 0.
REQ-040 The bench SHALL cover: rst asserted during data bit 3 -> txd=1, busy=0 and ti=0 immediately; after release, a write of 8'h55 transmits cleanly.
REQ-041 The bench SHALL cover: sm=10 with a write -> busy stays 0 and txd stays 1; smod toggled mid-frame -> bit lengths are unchanged.
